// File: rtl/mem_ctrl.sv
// ----------------------------------------------------------------------------
// mem_ctrl
// Byte-serial memory controller shared by instruction fetch and the
// load/store buffer. It arbitrates between the two requesters (LSB has
// priority), sequences 1/2/4-byte accesses over the 8-bit RAM/IO bus, and
// returns assembled little-endian data with a one-cycle done pulse.
//
// Optional feature macro: MEM_IO_STALL_EN
//   defined   : a store to the IO region (lsb_addr[17:16] == IO_REGION) is not
//               accepted while io_buffer_full is high; ifetch may go first.
//   undefined : io_buffer_full is ignored.
//
// Ports:
//   clk_in, rst_n_in      clock, asynchronous active-low reset
//   rdy_in                global ready; low freezes every register
//   rob_clear             ROB flush; aborts in-flight reads
//   if_req/if_addr        ifetch word read request
//   if_done/if_data       one-cycle completion pulse and fetched word
//   lsb_req/lsb_wr/lsb_size/lsb_addr/lsb_wdata   LSB load/store request
//   lsb_done/lsb_rdata    one-cycle completion pulse and zero-extended load
//   mem_din/mem_dout/mem_a/mem_wr   8-bit RAM/IO bus
//   io_buffer_full        IO output buffer full
// ----------------------------------------------------------------------------
module mem_ctrl #(
    parameter int unsigned ADDR_W    = 32,
    parameter logic [1:0]  IO_REGION = 2'b11
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              rob_clear,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              lsb_req,
    input  logic              lsb_wr,
    input  logic [1:0]        lsb_size,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [31:0]       lsb_wdata,
    output logic              lsb_done,
    output logic [31:0]       lsb_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [BYTE_W-1:0] mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic              if_done_q, if_done_d;
    logic              lsb_done_q, lsb_done_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] lsb_rdata_q, lsb_rdata_d;

    logic              io_block_c;
    logic              accept_ok_c;
    logic              grant_lsb_c;
    logic              grant_if_c;
    logic              last_c;
    logic [CNT_W-1:0]  lsb_n_c;
    logic [DATA_W-1:0] buf_ins_c;
    logic [BYTE_W-1:0] wbyte_c;

    // IO-region store back-pressure
`ifdef MEM_IO_STALL_EN
    assign io_block_c = io_buffer_full && (lsb_addr[17:16] == IO_REGION);
`else
    logic unused_io_c;
    assign unused_io_c = io_buffer_full | (^IO_REGION);
    assign io_block_c  = 1'b0;
`endif

    // Acceptance needs one idle cycle after any completion pulse
    assign accept_ok_c = (state_q == IDLE) && !if_done_q && !lsb_done_q;

    // LSB wins; a flush blocks loads and fetches but never stores
    assign grant_lsb_c = accept_ok_c && lsb_req && (lsb_wr ? !io_block_c : !rob_clear);
    assign grant_if_c  = accept_ok_c && !grant_lsb_c && if_req && !rob_clear;

    assign last_c = (cnt_q == n_q);

    // Access length from LSB size code
    always_comb begin
        case (lsb_size)
            2'b00:   lsb_n_c = 3'd1;
            2'b01:   lsb_n_c = 3'd2;
            default: lsb_n_c = 3'd4;
        endcase
    end

    // Assembly buffer with the byte arriving this edge inserted (byte cnt-1)
    always_comb begin
        buf_ins_c = buf_q;
        case (cnt_q)
            3'd1:    buf_ins_c[7:0]   = mem_din;
            3'd2:    buf_ins_c[15:8]  = mem_din;
            3'd3:    buf_ins_c[23:16] = mem_din;
            3'd4:    buf_ins_c[31:24] = mem_din;
            default: buf_ins_c = buf_q;
        endcase
    end

    // Store byte to drive next (byte cnt)
    always_comb begin
        case (cnt_q[1:0])
            2'd1:    wbyte_c = wdata_q[15:8];
            2'd2:    wbyte_c = wdata_q[23:16];
            2'd3:    wbyte_c = wdata_q[31:24];
            default: wbyte_c = wdata_q[7:0];
        endcase
    end

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_lsb_c) begin
                    state_d = lsb_wr ? LS_WR : LS_RD;
                end else if (grant_if_c) begin
                    state_d = IF_RD;
                end
            end
            IF_RD, LS_RD: begin
                if (rob_clear || last_c) begin
                    state_d = IDLE;
                end
            end
            LS_WR: begin
                if (last_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        cnt_d       = cnt_q;
        n_d         = n_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;
        if_done_d   = 1'b0;
        lsb_done_d  = 1'b0;
        if_data_d   = if_data_q;
        lsb_rdata_d = lsb_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_lsb_c) begin
                    addr_d   = lsb_addr;
                    n_d      = lsb_n_c;
                    wdata_d  = lsb_wdata;
                    buf_d    = '0;
                    mem_a_d  = lsb_addr;
                    mem_wr_d = lsb_wr;
                    cnt_d    = 3'd1;
                    if (lsb_wr) begin
                        mem_dout_d = lsb_wdata[7:0];
                    end
                end else if (grant_if_c) begin
                    addr_d   = if_addr;
                    n_d      = 3'd4;
                    buf_d    = '0;
                    mem_a_d  = if_addr;
                    mem_wr_d = 1'b0;
                    cnt_d    = 3'd1;
                end
            end
            IF_RD, LS_RD: begin
                if (rob_clear) begin
                    // Abort: no pulse, result registers keep their old value
                    mem_wr_d = 1'b0;
                    cnt_d    = '0;
                end else if (last_c) begin
                    mem_wr_d = 1'b0;
                    cnt_d    = '0;
                    if (state_q == IF_RD) begin
                        if_data_d = buf_ins_c;
                        if_done_d = 1'b1;
                    end else begin
                        lsb_rdata_d = buf_ins_c;
                        lsb_done_d  = 1'b1;
                    end
                end else begin
                    buf_d   = buf_ins_c;
                    mem_a_d = addr_q + ADDR_W'(cnt_q);
                    cnt_d   = cnt_q + 3'd1;
                end
            end
            LS_WR: begin
                if (last_c) begin
                    mem_wr_d   = 1'b0;
                    cnt_d      = '0;
                    lsb_done_d = 1'b1;
                end else begin
                    mem_a_d    = addr_q + ADDR_W'(cnt_q);
                    mem_dout_d = wbyte_c;
                    cnt_d      = cnt_q + 3'd1;
                end
            end
            default: begin
                mem_wr_d = 1'b0;
                cnt_d    = '0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q       <= '0;
            n_q         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            lsb_done_q  <= 1'b0;
            if_data_q   <= '0;
            lsb_rdata_q <= '0;
        end else if (rdy_in) begin
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            if_done_q   <= if_done_d;
            lsb_done_q  <= lsb_done_d;
            if_data_q   <= if_data_d;
            lsb_rdata_q <= lsb_rdata_d;
        end
    end

    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = mem_wr_q;
    assign if_done   = if_done_q;
    assign lsb_done  = lsb_done_q;
    assign if_data   = if_data_q;
    assign lsb_rdata = lsb_rdata_q;

endmodule
